// File: rtl/mastermind_pkg.sv
// ============================================================================
// Package  : mastermind_pkg
// Summary  : Shared Mastermind code, history and solver-state definitions.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mastermind_pkg;

    localparam int NUM_PEGS   = 4;
    localparam int COLOR_W    = 3;
    localparam int NUM_COLORS = 8;
    localparam int CODE_W     = NUM_PEGS * COLOR_W;

    typedef logic [CODE_W-1:0]  code_t;
    typedef logic [COLOR_W-1:0] color_t;

    typedef struct packed {
        code_t      code;
        logic [2:0] exact;
        logic [2:0] partial;
    } hist_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EMIT    = 3'd1,
        ST_WAIT_FB = 3'd2,
        ST_SEARCH  = 3'd3,
        ST_SOLVED  = 3'd4,
        ST_FAILED  = 3'd5
    } state_t;

    // Peg p of a code; peg 0 occupies the least significant bits.
    function automatic color_t peg(input code_t c, input int p);
        return c[p*COLOR_W +: COLOR_W];
    endfunction

endpackage

`default_nettype wire

// File: rtl/mastermind_solver_if.sv
// ============================================================================
// Interface : mastermind_solver_if
// Summary   : Guess/feedback handshake between the solver and the codemaker.
// Config    : MASTERMIND_SOLVER_STATS_EN adds search_cycles
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mastermind_solver_if;

    logic       start;
    logic       fb_valid;
    logic [2:0] fb_exact;
    logic [2:0] fb_partial;
    logic [2:0] guess0;
    logic [2:0] guess1;
    logic [2:0] guess2;
    logic [2:0] guess3;
    logic       guess_valid;
    logic [2:0] turn;
    logic       busy;
    logic       solved;
    logic       failed;
`ifdef MASTERMIND_SOLVER_STATS_EN
    logic [15:0] search_cycles;
`endif

    modport master (
`ifdef MASTERMIND_SOLVER_STATS_EN
        output search_cycles,
`endif
        input  start, fb_valid, fb_exact, fb_partial,
        output guess0, guess1, guess2, guess3,
        output guess_valid, turn, busy, solved, failed
    );

    modport slave (
`ifdef MASTERMIND_SOLVER_STATS_EN
        input  search_cycles,
`endif
        output start, fb_valid, fb_exact, fb_partial,
        input  guess0, guess1, guess2, guess3,
        input  guess_valid, turn, busy, solved, failed
    );

endinterface

`default_nettype wire

// File: rtl/peg_scorer.sv
// ============================================================================
// Module   : peg_scorer
// Summary  : Combinational Mastermind scorer: exact and colour-only matches.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module peg_scorer
    import mastermind_pkg::*;
(
    input  code_t      code_a,
    input  code_t      code_b,
    output logic [2:0] exact,
    output logic [2:0] partial
);

    logic [2:0] w_cnt_a;
    logic [2:0] w_cnt_b;
    logic [2:0] w_common;

    always_comb begin
        exact    = '0;
        w_common = '0;
        w_cnt_a  = '0;
        w_cnt_b  = '0;
        for (int p = 0; p < NUM_PEGS; p++) begin
            if (peg(code_a, p) == peg(code_b, p)) begin
                exact = exact + 3'd1;
            end
        end
        // Colours shared regardless of position, then remove the exact hits.
        for (int c = 0; c < NUM_COLORS; c++) begin
            w_cnt_a = '0;
            w_cnt_b = '0;
            for (int p = 0; p < NUM_PEGS; p++) begin
                if (peg(code_a, p) == color_t'(c)) w_cnt_a = w_cnt_a + 3'd1;
                if (peg(code_b, p) == color_t'(c)) w_cnt_b = w_cnt_b + 3'd1;
            end
            w_common = w_common + ((w_cnt_a < w_cnt_b) ? w_cnt_a : w_cnt_b);
        end
        partial = w_common - exact;
    end

endmodule

`default_nettype wire

// File: rtl/mastermind_solver.sv
// ============================================================================
// Module   : mastermind_solver
// Summary  : Codebreaker issuing the first guess consistent with all feedback.
// Config   : MASTERMIND_SOLVER_STATS_EN adds the search_cycles counter
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mastermind_solver
    import mastermind_pkg::*;
#(
    parameter int MAX_TURNS = 8
) (
    input  logic                clk,
    input  logic                rst,
    mastermind_solver_if.master bus
);

    state_t     r_state;
    state_t     w_state_next;
    code_t      r_cand;
    code_t      r_guess;
    logic [3:0] r_turn;
    logic [2:0] r_idx;
    hist_t      r_hist [MAX_TURNS];

    logic       w_new_game;
    logic       w_latch;
    logic       w_store;
    logic       w_cand_inc;
    logic       w_idx_inc;
    logic       w_idx_clr;
    logic [2:0] w_sc_exact;
    logic [2:0] w_sc_partial;
    logic       w_match;
    logic       w_cand_last;

    peg_scorer u_scorer (
        .code_a  (r_cand),
        .code_b  (r_hist[r_idx].code),
        .exact   (w_sc_exact),
        .partial (w_sc_partial)
    );

    assign w_match     = (w_sc_exact == r_hist[r_idx].exact) &&
                         (w_sc_partial == r_hist[r_idx].partial);
    assign w_cand_last = &r_cand;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_new_game      = 1'b0;
        w_latch         = 1'b0;
        w_store         = 1'b0;
        w_cand_inc      = 1'b0;
        w_idx_inc       = 1'b0;
        w_idx_clr       = 1'b0;
        bus.guess_valid = (r_state == ST_WAIT_FB);
        bus.busy        = (r_state == ST_SEARCH);
        bus.solved      = (r_state == ST_SOLVED);
        bus.failed      = (r_state == ST_FAILED);
        if (bus.start) begin
            w_new_game   = 1'b1;
            w_state_next = ST_EMIT;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_next = ST_IDLE;
                end
                ST_EMIT: begin
                    w_latch      = 1'b1;
                    w_state_next = ST_WAIT_FB;
                end
                ST_WAIT_FB: begin
                    if (bus.fb_valid) begin
                        w_store = 1'b1;
                        if (bus.fb_exact == 3'd4) begin
                            w_state_next = ST_SOLVED;
                        end else if ((r_turn + 4'd1) == 4'(MAX_TURNS)) begin
                            w_state_next = ST_FAILED;
                        end else if (w_cand_last) begin
                            w_state_next = ST_FAILED;
                        end else begin
                            w_cand_inc   = 1'b1;
                            w_idx_clr    = 1'b1;
                            w_state_next = ST_SEARCH;
                        end
                    end
                end
                ST_SEARCH: begin
                    if (!w_match) begin
                        // The code space is never wrapped: running off the end means no answer exists.
                        if (w_cand_last) begin
                            w_state_next = ST_FAILED;
                        end else begin
                            w_cand_inc = 1'b1;
                            w_idx_clr  = 1'b1;
                        end
                    end else if ({1'b0, r_idx} == (r_turn - 4'd1)) begin
                        w_state_next = ST_EMIT;
                    end else begin
                        w_idx_inc = 1'b1;
                    end
                end
                ST_SOLVED: begin
                    w_state_next = ST_SOLVED;
                end
                ST_FAILED: begin
                    w_state_next = ST_FAILED;
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_new_game) begin
            r_cand  <= '0;
            r_guess <= '0;
            r_turn  <= '0;
            r_idx   <= '0;
            for (int k = 0; k < MAX_TURNS; k++) begin
                r_hist[k] <= '0;
            end
        end else begin
            if (w_latch) begin
                r_guess <= r_cand;
            end
            if (w_store) begin
                r_hist[r_turn[2:0]] <= '{code: r_guess, exact: bus.fb_exact, partial: bus.fb_partial};
                r_turn              <= r_turn + 4'd1;
            end
            if (w_cand_inc) begin
                r_cand <= r_cand + 12'd1;
            end
            if (w_idx_clr) begin
                r_idx <= '0;
            end else if (w_idx_inc) begin
                r_idx <= r_idx + 3'd1;
            end
        end
    end

    assign bus.guess0 = r_guess[2:0];
    assign bus.guess1 = r_guess[5:3];
    assign bus.guess2 = r_guess[8:6];
    assign bus.guess3 = r_guess[11:9];
    // The display field is 3 bits wide; a full eight-turn game shows as 7.
    assign bus.turn   = (r_turn > 4'd7) ? 3'd7 : r_turn[2:0];

`ifdef MASTERMIND_SOLVER_STATS_EN
    logic [15:0] r_search_cycles;

    always_ff @(posedge clk) begin
        if (rst || w_new_game) begin
            r_search_cycles <= '0;
        end else if ((w_state_next == ST_SEARCH) && (r_state != ST_SEARCH)) begin
            r_search_cycles <= '0;
        end else if ((r_state == ST_SEARCH) && (r_search_cycles != 16'hFFFF)) begin
            r_search_cycles <= r_search_cycles + 16'd1;
        end
    end

    assign bus.search_cycles = r_search_cycles;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mastermind_solver.sv
// ============================================================================
// Module   : tb_mastermind_solver
// Summary  : Self-checking bench: feedback table, corner sequences, model games.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mastermind_solver;
    import mastermind_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mastermind_solver_if bus ();
    mastermind_solver_if bus2 ();

    mastermind_solver #(.MAX_TURNS(8)) dut (.clk(clk), .rst(rst), .bus(bus.master));
    mastermind_solver #(.MAX_TURNS(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.master));

    int checks = 0;
    int errors = 0;

    int h_code[$];
    int h_ex[$];
    int h_pa[$];

    typedef struct {
        int e;
        int p;
        bit exp_solved;
        bit exp_failed;
        int exp_guess;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic note_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for the solver", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int guess_code();
        return int'({bus.guess3, bus.guess2, bus.guess1, bus.guess0});
    endfunction

    function automatic int m_peg(input int code, input int p);
        return (code >> (3 * p)) & 7;
    endfunction

    function automatic void m_score(input int a, input int b, output int e, output int p);
        int ca[8];
        int cb[8];
        int common;
        e = 0;
        common = 0;
        for (int c = 0; c < 8; c++) begin
            ca[c] = 0;
            cb[c] = 0;
        end
        for (int k = 0; k < 4; k++) begin
            if (m_peg(a, k) == m_peg(b, k)) e++;
            ca[m_peg(a, k)]++;
            cb[m_peg(b, k)]++;
        end
        for (int c = 0; c < 8; c++) common += (ca[c] < cb[c]) ? ca[c] : cb[c];
        p = common - e;
    endfunction

    function automatic bit m_consistent(input int c);
        int e;
        int p;
        foreach (h_code[i]) begin
            m_score(c, h_code[i], e, p);
            if (e != h_ex[i] || p != h_pa[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int m_next(input int from);
        for (int c = from; c < 4096; c++) begin
            if (m_consistent(c)) return c;
        end
        return -1;
    endfunction

    task automatic start_game();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic apply_fb(input int e, input int p);
        bus.fb_valid   = 1'b1;
        bus.fb_exact   = 3'(e);
        bus.fb_partial = 3'(p);
        tick();
        bus.fb_valid = 1'b0;
    endtask

    task automatic wait_out(input int budget, output bit saw_gv, output bit to);
        saw_gv = 1'b0;
        to     = 1'b1;
        for (int k = 0; k < budget; k++) begin
            if (bus.guess_valid) saw_gv = 1'b1;
            if (bus.guess_valid || bus.solved || bus.failed) begin
                to = 1'b0;
                break;
            end
            tick();
        end
    endtask

    task automatic play_game(input int secret, input string tag);
        int  exp_g;
        int  n;
        int  e;
        int  p;
        bit  done;
        bit  saw;
        bit  to;
        h_code.delete();
        h_ex.delete();
        h_pa.delete();
        start_game();
        check({tag, "_gv_n1"}, bus.guess_valid, 0);
        tick();
        check({tag, "_gv_n2"}, bus.guess_valid, 1);
        exp_g = 0;
        n     = 0;
        done  = 1'b0;
        while (!done) begin
            wait_out(40000, saw, to);
            if (to) begin
                note_timeout(tag);
                return;
            end
            if (exp_g < 0) begin
                check({tag, "_exhausted_failed"}, bus.failed, 1);
                check({tag, "_exhausted_gv"}, bus.guess_valid, 0);
                done = 1'b1;
            end else begin
                check({tag, "_gv"}, bus.guess_valid, 1);
                check({tag, "_guess"}, guess_code(), exp_g);
                m_score(exp_g, secret, e, p);
                apply_fb(e, p);
                n++;
                h_code.push_back(exp_g);
                h_ex.push_back(e);
                h_pa.push_back(p);
                if (e == 4) begin
                    check({tag, "_solved"}, bus.solved, 1);
                    check({tag, "_turn"}, bus.turn, (n > 7) ? 7 : n);
                    check({tag, "_gv_off"}, bus.guess_valid, 0);
                    done = 1'b1;
                end else if (n == 8) begin
                    check({tag, "_turnlimit_failed"}, bus.failed, 1);
                    check({tag, "_solved_off"}, bus.solved, 0);
                    done = 1'b1;
                end else begin
                    check({tag, "_busy"}, bus.busy, 1);
                    check({tag, "_turn"}, bus.turn, n);
                    exp_g = m_next(exp_g + 1);
                end
            end
        end
    endtask

    initial begin
        bit saw;
        bit to;
        rst = 1'b1;
        bus.start = 1'b0;   bus.fb_valid = 1'b0;  bus.fb_exact = '0;  bus.fb_partial = '0;
        bus2.start = 1'b0;  bus2.fb_valid = 1'b0; bus2.fb_exact = '0; bus2.fb_partial = '0;

        // First-feedback responses to guess 0000 and the guess each one forces next.
        vecs[0] = '{e: 0, p: 0, exp_solved: 0, exp_failed: 0, exp_guess: 12'o1111};
        vecs[1] = '{e: 1, p: 0, exp_solved: 0, exp_failed: 0, exp_guess: 12'o0111};
        vecs[2] = '{e: 2, p: 0, exp_solved: 0, exp_failed: 0, exp_guess: 12'o0011};
        vecs[3] = '{e: 3, p: 0, exp_solved: 0, exp_failed: 0, exp_guess: 12'o0001};
        vecs[4] = '{e: 4, p: 0, exp_solved: 1, exp_failed: 0, exp_guess: 0};
        vecs[5] = '{e: 3, p: 1, exp_solved: 0, exp_failed: 1, exp_guess: 0};

        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_gv", bus.guess_valid, 0);
        check("rst_guess", guess_code(), 0);
        check("rst_turn", bus.turn, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_solved", bus.solved, 0);
        check("rst_failed", bus.failed, 0);

        for (int v = 0; v < 6; v++) begin
            start_game();
            tick();
            check("tbl_gv_first", bus.guess_valid, 1);
            check("tbl_guess_first", guess_code(), 0);
            apply_fb(vecs[v].e, vecs[v].p);
            check("tbl_turn", bus.turn, 1);
            check("tbl_solved", bus.solved, 32'(vecs[v].exp_solved));
            if (vecs[v].exp_solved) begin
                check("tbl_solved_guess_held", guess_code(), 0);
                check("tbl_solved_failed", bus.failed, 0);
            end else begin
                check("tbl_busy", bus.busy, 1);
                wait_out(6000, saw, to);
                if (to) begin
                    note_timeout("tbl_wait");
                end else begin
                    check("tbl_failed", bus.failed, 32'(vecs[v].exp_failed));
                    check("tbl_gv", bus.guess_valid, 32'(!vecs[v].exp_failed));
                    if (vecs[v].exp_failed) check("tbl_no_guess_emitted", 32'(saw), 0);
                    else check("tbl_next_guess", guess_code(), vecs[v].exp_guess);
                end
            end
        end

        // Turn limit of two, secret 7777.
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        tick();
        check("t2_gv", bus2.guess_valid, 1);
        bus2.fb_valid = 1'b1; bus2.fb_exact = 3'd0; bus2.fb_partial = 3'd0;
        tick();
        bus2.fb_valid = 1'b0;
        check("t2_turn1", bus2.turn, 1);
        check("t2_failed_early", bus2.failed, 0);
        for (int k = 0; k < 2000 && !bus2.guess_valid; k++) tick();
        check("t2_second_guess", int'({bus2.guess3, bus2.guess2, bus2.guess1, bus2.guess0}), 12'o1111);
        bus2.fb_valid = 1'b1;
        tick();
        bus2.fb_valid = 1'b0;
        check("t2_failed", bus2.failed, 1);
        check("t2_turn2", bus2.turn, 2);
        check("t2_gv_off", bus2.guess_valid, 0);

        // Stray feedback during a search, then restart mid-search.
        start_game();
        tick();
        apply_fb(3, 1);
        repeat (5) tick();
        bus.fb_valid = 1'b1; bus.fb_exact = 3'd4; bus.fb_partial = 3'd0;
        repeat (2) tick();
        bus.fb_valid = 1'b0;
        check("stray_turn", bus.turn, 1);
        check("stray_busy", bus.busy, 1);
        check("stray_solved", bus.solved, 0);
        start_game();
        check("restart_turn", bus.turn, 0);
        check("restart_busy", bus.busy, 0);
        tick();
        check("restart_gv", bus.guess_valid, 1);
        check("restart_guess", guess_code(), 0);

        // start together with feedback in WAIT_FB: the restart wins.
        apply_fb(0, 0);
        wait_out(2000, saw, to);
        check("pre_tie_guess", guess_code(), 12'o1111);
        bus.start = 1'b1; bus.fb_valid = 1'b1; bus.fb_exact = 3'd4;
        tick();
        bus.start = 1'b0; bus.fb_valid = 1'b0;
        check("tie_turn", bus.turn, 0);
        check("tie_solved", bus.solved, 0);
        tick();
        check("tie_gv", bus.guess_valid, 1);
        check("tie_guess", guess_code(), 0);

        // Reset while a non-zero guess awaits feedback.
        apply_fb(0, 0);
        wait_out(2000, saw, to);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstw_guess", guess_code(), 0);
        check("rstw_gv", bus.guess_valid, 0);
        check("rstw_turn", bus.turn, 0);
        check("rstw_busy", bus.busy, 0);
        check("rstw_solved", bus.solved, 0);
        check("rstw_failed", bus.failed, 0);

        play_game(12'o4321, "g1234");
        play_game(12'o0007, "g7000");
        play_game(12'o5566, "g6655");
        for (int r = 0; r < 3; r++) play_game(int'($urandom_range(0, 4095)), "grand");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
